// File: rtl/nx1_row_sequencer.sv
// nx1_row_sequencer
// Wishbone classic master for the Neuromorphic X1 32x32 command port.
// A local row request becomes 32 PROGRAM or READ command writes to one
// address. Reads are followed by result polling until all 32 column bits
// have been collected. Every Wishbone and response output is a flop.
module nx1_row_sequencer #(
  parameter logic [31:0] ADDR        = 32'h3000_0000,
  parameter int          ACK_TIMEOUT = 64,
  parameter int          POLL_GAP    = 8,
  parameter int          MAX_POLLS   = 1024
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [4:0]  req_row,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  // Result word the X1 returns while no column result is ready yet.
  localparam logic [31:0] EMPTY_WORD = 32'hDEAD_C0DE;
  localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ISSUE_GAP,
    S_POLL,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // PROGRAM command: full-byte 0xFF sets the cell, 0x00 clears it.
  function automatic logic [31:0] prog_cmd(input logic [4:0] row,
                                           input logic [4:0] col,
                                           input logic       b);
    return {2'b11, row, col, 12'b0, (b ? 8'hFF : 8'h00)};
  endfunction

  function automatic logic [31:0] read_cmd(input logic [4:0] row,
                                           input logic [4:0] col);
    return {2'b01, row, col, 20'b0};
  endfunction

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic [4:0]          row_q, row_d;
  logic [31:0]         data_q, data_d;
  logic [4:0]          col_q, col_d;
  logic [4:0]          rcol_q, rcol_d;
  logic [31:0]         row_buf_q, row_buf_d;
  logic                bad_q, bad_d;
  logic [POLL_W-1:0]   polls_q, polls_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [3:0]          sel_q, sel_d;
  logic [31:0]         adr_q, adr_d;
  logic [31:0]         dat_o_q, dat_o_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                xfer_ack;
  logic                tmo_hit;
  logic                accept;

  // An ack only counts while our strobe is actually up.
  assign xfer_ack = stb_q && wbm_ack_i;
  assign tmo_hit  = stb_q && !wbm_ack_i && (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
  assign accept   = req_valid && req_ready_q;

  // Next-state, bookkeeping and registered-output computation.
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    row_d       = row_q;
    data_d      = data_q;
    col_d       = col_q;
    rcol_d      = rcol_q;
    row_buf_d   = row_buf_q;
    bad_d       = bad_q;
    polls_d     = polls_q;
    gap_d       = gap_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = 1'b0;
    tmo_d       = (stb_q && !wbm_ack_i) ? tmo_q + 1'b1 : '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wr_d      = req_wr;
          row_d     = req_row;
          data_d    = req_data;
          col_d     = 5'd0;
          rcol_d    = 5'd0;
          row_buf_d = 32'd0;
          bad_d     = 1'b0;
          polls_d   = '0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tmo_hit) begin
          state_d = S_ERR;
        end else if (xfer_ack) begin
          if (col_q == 5'd31) begin
            state_d = wr_q ? S_DONE : S_POLL;
          end else begin
            col_d   = col_q + 5'd1;
            state_d = S_ISSUE_GAP;
          end
        end
      end
      S_ISSUE_GAP: begin
        state_d = S_ISSUE;
      end
      S_POLL: begin
        if (tmo_hit) begin
          state_d = S_ERR;
        end else if (xfer_ack) begin
          if (wbm_dat_i == EMPTY_WORD) begin
            polls_d = polls_q + 1'b1;
            if (polls_d == POLL_W'(MAX_POLLS)) begin
              state_d = S_ERR;
            end else begin
              gap_d   = GAP_W'(POLL_GAP);
              state_d = S_WAIT;
            end
          end else begin
            row_buf_d[rcol_q] = wbm_dat_i[0];
            polls_d           = '0;
            bad_d             = bad_q | (|wbm_dat_i[31:1]);
            if (rcol_q == 5'd31) begin
              state_d = S_DONE;
            end else begin
              rcol_d  = rcol_q + 5'd1;
              gap_d   = GAP_W'(1);
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = S_POLL;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobe drops on the ack edge, which also guarantees an idle cycle
    // between any two transfers (including ISSUE -> POLL).
    stb_d   = ((state_d == S_ISSUE) || (state_d == S_POLL)) && !xfer_ack;
    cyc_d   = stb_d;
    we_d    = stb_d && (state_d == S_ISSUE);
    sel_d   = stb_d ? 4'hF : 4'h0;
    adr_d   = stb_d ? ADDR : 32'd0;
    dat_o_d = 32'd0;
    if (stb_d && (state_d == S_ISSUE)) begin
      dat_o_d = wr_d ? prog_cmd(row_d, col_d, data_d[col_d])
                     : read_cmd(row_d, col_d);
    end

    req_ready_d = (state_d == S_IDLE);

    if (state_d == S_DONE) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = wr_d ? data_d : row_buf_d;
      rsp_err_d   = bad_d;
    end else if (state_d == S_ERR) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = row_buf_d;
      rsp_err_d   = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Request context, column counters and read assembly buffer.
  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      wr_q      <= 1'b0;
      row_q     <= 5'd0;
      data_q    <= 32'd0;
      col_q     <= 5'd0;
      rcol_q    <= 5'd0;
      row_buf_q <= 32'd0;
      bad_q     <= 1'b0;
      polls_q   <= '0;
      gap_q     <= '0;
      tmo_q     <= '0;
    end else begin
      wr_q      <= wr_d;
      row_q     <= row_d;
      data_q    <= data_d;
      col_q     <= col_d;
      rcol_q    <= rcol_d;
      row_buf_q <= row_buf_d;
      bad_q     <= bad_d;
      polls_q   <= polls_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
    end
  end

  // Registered Wishbone master and response outputs.
  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'd0;
      dat_o_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_o_q     <= dat_o_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_o_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_nx1_row_sequencer.sv
// Bench for nx1_row_sequencer: an X1 slave model with a 32x32 cell array,
// a command scoreboard and a response scoreboard.
module tb_nx1_row_sequencer;

  localparam logic [31:0] ADDR        = 32'h3000_0000;
  localparam int          ACK_TIMEOUT = 64;
  localparam int          POLL_GAP    = 8;
  localparam int          MAX_POLLS   = 1024;
  localparam logic [31:0] DEAD        = 32'hDEAD_C0DE;

  logic        CLKin, RSTin;
  logic        req_valid, req_ready, req_wr;
  logic [4:0]  req_row;
  logic [31:0] req_data;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  nx1_row_sequencer #(
    .ADDR(ADDR), .ACK_TIMEOUT(ACK_TIMEOUT), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)
  ) dut (
    .CLKin(CLKin), .RSTin(RSTin),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_row(req_row), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  initial CLKin = 1'b0;
  always #5 CLKin = ~CLKin;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] prog_cmd(input logic [4:0] r, input logic [4:0] c, input logic b);
    return {2'b11, r, c, 12'b0, (b ? 8'hFF : 8'h00)};
  endfunction

  function automatic logic [31:0] read_cmd(input logic [4:0] r, input logic [4:0] c);
    return {2'b01, r, c, 20'b0};
  endfunction

  // ---------------- X1 slave model ----------------
  typedef struct packed { logic [4:0] col; logic b; } rq_t;
  logic [31:0] mem [32];
  rq_t         rq [$];
  rq_t         s_e;
  logic [4:0]  s_row, s_col;
  logic        alt;
  logic        ack_en, dead_mode, corrupt7;

  // Registered ack one cycle after strobe; empty word is returned before
  // each real result so the master has to retry.
  always @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      wbm_ack_i <= 1'b0;
      wbm_dat_i <= 32'd0;
      alt       <= 1'b0;
      rq.delete();
    end else begin
      wbm_ack_i <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && ack_en) begin
        wbm_ack_i <= 1'b1;
        if (wbm_we_o) begin
          s_row = wbm_dat_o[29:25];
          s_col = wbm_dat_o[24:20];
          if (wbm_dat_o[31:30] == 2'b11)
            mem[s_row][s_col] = (wbm_dat_o[7:0] == 8'hFF);
          else if (wbm_dat_o[31:30] == 2'b01 && !dead_mode)
            rq.push_back('{col: s_col, b: mem[s_row][s_col]});
        end else begin
          if (dead_mode || rq.size() == 0 || !alt) begin
            wbm_dat_i <= DEAD;
            if (!dead_mode && rq.size() != 0) alt <= 1'b1;
          end else begin
            s_e = rq.pop_front();
            wbm_dat_i <= (corrupt7 && s_e.col == 5'd7) ? 32'h0000_0003 : {31'b0, s_e.b};
            alt <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------- bus monitor / command scoreboard ----------------
  logic [31:0] cmd_q [$];
  logic [32:0] rsp_q [$];
  logic [31:0] exp_cmd;
  logic        prev_acked = 1'b0, prev_stb = 1'b0, prev_dead_poll = 1'b0;
  int          poll_cnt = 0, low_run = 0, gap_min = 0, gap_max = 0;

  always @(negedge CLKin) begin
    if (prev_acked) check("no_b2b_stb", {31'b0, wbm_stb_o}, 32'd0);
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
      if (wbm_we_o) begin
        n_tests++;
        assert (cmd_q.size() != 0) else begin
          n_fail++;
          $error("FAIL cmd_extra: observed %h expected no command", wbm_dat_o);
        end
        if (cmd_q.size() != 0) begin
          exp_cmd = cmd_q.pop_front();
          check("cmd_word", wbm_dat_o, exp_cmd);
        end
        check("cmd_adr", wbm_adr_o, ADDR);
        check("cmd_sel", {28'b0, wbm_sel_o}, 32'h0000_000F);
      end else begin
        poll_cnt++;
      end
    end
    if (!wbm_stb_o) begin
      low_run++;
    end else if (!prev_stb) begin
      if (!wbm_we_o && prev_dead_poll) begin
        if (low_run < gap_min) gap_min = low_run;
        if (low_run > gap_max) gap_max = low_run;
      end
      low_run = 0;
    end
    if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && !wbm_we_o)
      prev_dead_poll = (wbm_dat_i == DEAD);
    prev_acked = wbm_cyc_o && wbm_stb_o && wbm_ack_i;
    prev_stb   = wbm_stb_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_req(input logic wr, input logic [4:0] row, input logic [31:0] data,
                        input logic [31:0] exp_data, input logic exp_err);
    for (int c = 0; c < 32; c++)
      cmd_q.push_back(wr ? prog_cmd(row, 5'(c), data[c]) : read_cmd(row, 5'(c)));
    rsp_q.push_back({exp_err, exp_data});
    @(negedge CLKin);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_row   = row;
    req_data  = data;
    @(negedge CLKin);
    req_valid = 1'b0;
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);
  endtask

  task automatic wait_rsp(input int budget, output int cycles);
    logic        got;
    logic [32:0] e;
    cycles = 0;
    got    = 1'b0;
    while (cycles < budget && !got) begin
      @(negedge CLKin);
      cycles++;
      got = rsp_valid;
    end
    check("rsp_seen", {31'b0, got}, 32'd1);
    if (got && rsp_q.size() != 0) begin
      e = rsp_q.pop_front();
      check("rsp_data", rsp_data, e[31:0]);
      check("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
    end
  endtask

  int cyc;

  initial begin
    for (int r = 0; r < 32; r++) mem[r] = 32'd0;
    ack_en = 1'b1; dead_mode = 1'b0; corrupt7 = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_row = 5'd0; req_data = 32'd0;
    RSTin = 1'b1;
    repeat (3) @(negedge CLKin);

    // Reset state
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("rst_we", {31'b0, wbm_we_o}, 32'd0);
    check("rst_sel", {28'b0, wbm_sel_o}, 32'd0);
    check("rst_adr", wbm_adr_o, 32'd0);
    check("rst_dat_o", wbm_dat_o, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    RSTin = 1'b0;
    @(negedge CLKin);

    // Program row 5; a stray request mid-operation must be ignored.
    do_req(1'b1, 5'd5, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0);
    repeat (10) @(negedge CLKin);
    req_valid = 1'b1; req_wr = 1'b0; req_row = 5'd3; req_data = 32'hFFFF_FFFF;
    repeat (5) @(negedge CLKin);
    req_valid = 1'b0;
    wait_rsp(2000, cyc);
    repeat (3) @(negedge CLKin);
    check("rsp_valid_pulse", {31'b0, rsp_valid}, 32'd0);
    check("rsp_data_hold", rsp_data, 32'hA5A5_5A5A);

    // Read row 5 back through empty-word retries.
    do_req(1'b0, 5'd5, 32'd0, 32'hA5A5_5A5A, 1'b0);
    wait_rsp(5000, cyc);

    // Edge columns: row 31 with only col 0 and col 31 set.
    do_req(1'b1, 5'd31, 32'h8000_0001, 32'h8000_0001, 1'b0);
    wait_rsp(2000, cyc);
    do_req(1'b0, 5'd31, 32'd0, 32'h8000_0001, 1'b0);
    wait_rsp(5000, cyc);

    // Ack never arrives: error exactly ACK_TIMEOUT cycles after first strobe.
    ack_en = 1'b0;
    do_req(1'b1, 5'd2, 32'h0000_0001, 32'h0000_0000, 1'b1);
    check("tmo_stb_up", {31'b0, wbm_stb_o}, 32'd1);
    wait_rsp(200, cyc);
    check("tmo_latency", cyc, ACK_TIMEOUT);
    check("tmo_cyc_low", {31'b0, wbm_cyc_o}, 32'd0);
    ack_en = 1'b1;
    cmd_q.delete();
    repeat (2) @(negedge CLKin);

    // Slave always empty: error after MAX_POLLS polls spaced POLL_GAP apart.
    dead_mode = 1'b1;
    poll_cnt = 0; gap_min = 1_000_000; gap_max = 0;
    do_req(1'b0, 5'd5, 32'd0, 32'h0000_0000, 1'b1);
    wait_rsp(20000, cyc);
    check("dead_poll_count", poll_cnt, MAX_POLLS);
    check("dead_gap_min", gap_min, POLL_GAP);
    check("dead_gap_max", gap_max, POLL_GAP);
    dead_mode = 1'b0;
    repeat (2) @(negedge CLKin);

    // Bad result word at column 7: bit kept, sticky error reported.
    corrupt7 = 1'b1;
    do_req(1'b0, 5'd5, 32'd0, 32'hA5A5_5ADA, 1'b1);
    wait_rsp(5000, cyc);
    corrupt7 = 1'b0;
    repeat (2) @(negedge CLKin);

    // Reset in the middle of a read aborts without a response.
    do_req(1'b0, 5'd5, 32'd0, 32'd0, 1'b0);
    repeat (60) @(negedge CLKin);
    RSTin = 1'b1;
    #1;
    check("abort_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("abort_stb", {31'b0, wbm_stb_o}, 32'd0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge CLKin);
    RSTin = 1'b0;
    cmd_q.delete();
    rsp_q.delete();
    repeat (5) @(negedge CLKin);
    check("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Fresh read of an unprogrammed row.
    do_req(1'b0, 5'd0, 32'd0, 32'h0000_0000, 1'b0);
    wait_rsp(5000, cyc);
    check("cmd_queue_drained", cmd_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
